// File: rtl/fp_div_normalize_pkg.sv
// Shared floating-point definitions for the divide/multiply back ends.
// Single-precision default widths, bias, packed float layout and rounding modes.
package fp_div_normalize_pkg;

  localparam int unsigned FP_EXP_W    = 8;
  localparam int unsigned FP_FRAC_W   = 23;
  localparam int unsigned FP_BIAS     = 2**(FP_EXP_W-1) - 1;
  localparam int unsigned FP_EXP_ONES = 2**FP_EXP_W - 1;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_t;

  // Only round-to-nearest-even exists today; encoding leaves room for more modes.
  typedef enum logic [1:0] {
    RND_RNE = 2'd0
  } rnd_mode_e;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational fraction rounder: adds the rounding increment and reports
// the carry out of the fraction so the caller can bump the exponent.
module fp_round_rne
  import fp_div_normalize_pkg::*;
#(
  parameter int unsigned FRAC_W = FP_FRAC_W,
  parameter rnd_mode_e   MODE   = RND_RNE
) (
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_r,
  output logic              carry
);

  logic          inc;
  logic [FRAC_W:0] sum;

  always_comb begin
    inc = 1'b0;
    if (MODE == RND_RNE) inc = guard & (sticky | frac[0]);
    sum    = {1'b0, frac} + (FRAC_W+1)'(inc);
    frac_r = sum[FRAC_W-1:0];
    carry  = sum[FRAC_W];
  end

endmodule

// File: rtl/fp_div_normalize.sv
// Divide back end: 1-bit normalization, round-to-nearest-even, range check and
// IEEE-754 pack, as a two-stage valid/ready pipeline.
module fp_div_normalize
  import fp_div_normalize_pkg::*;
#(
  parameter int unsigned EXP_W  = FP_EXP_W,
  parameter int unsigned FRAC_W = FP_FRAC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W+1:0]          in_exp,
  input  logic [FRAC_W+2:0]         in_q,
  input  logic                      in_rem_nz,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic                      out_decrement,
  output logic                      out_of,
  output logic                      out_uf
);

  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned QW = FRAC_W + 3;
  localparam int unsigned RW = 1 + EXP_W + FRAC_W;
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

  // Stage-1 pipeline register
  logic                   s1_valid;
  logic                   s1_sign;
  logic signed [EW-1:0]   s1_exp;
  logic [FRAC_W-1:0]      s1_frac;
  logic                   s1_guard;
  logic                   s1_sticky;
  logic                   s1_dec;

  logic                   s2_free;
  logic                   dec_c;
  logic [FRAC_W-1:0]      frac_c;
  logic                   guard_c;
  logic                   sticky_c;
  logic signed [EW-1:0]   e1_c;

  logic [FRAC_W-1:0]      frac_r_c;
  logic                   carry_c;
  logic signed [EW-1:0]   e2_c;
  logic                   of_c;
  logic                   uf_c;
  logic [RW-1:0]          result_c;

  assign s2_free  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_free;

  // Quotient below 1.0 needs one left shift, which costs one exponent step.
  always_comb begin
    dec_c = ~in_q[QW-1];
    if (dec_c) begin
      frac_c   = in_q[FRAC_W:1];
      guard_c  = in_q[0];
      sticky_c = in_rem_nz;
    end else begin
      frac_c   = in_q[FRAC_W+1:2];
      guard_c  = in_q[1];
      sticky_c = in_q[0] | in_rem_nz;
    end
    e1_c = in_exp - EW'(dec_c);
  end

  fp_round_rne #(
    .FRAC_W (FRAC_W),
    .MODE   (RND_RNE)
  ) u_round (
    .frac   (s1_frac),
    .guard  (s1_guard),
    .sticky (s1_sticky),
    .frac_r (frac_r_c),
    .carry  (carry_c)
  );

  // Rounding carry leaves frac_r at zero, so only the exponent moves.
  always_comb begin
    e2_c = s1_exp + EW'(carry_c);
    of_c = 1'b0;
    uf_c = 1'b0;
    result_c = {s1_sign, e2_c[EXP_W-1:0], frac_r_c};
    if (e2_c >= EXP_MAX) begin
      of_c     = 1'b1;
      result_c = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (e2_c[EW-1] || (e2_c == '0)) begin
      uf_c     = 1'b1;
      result_c = {s1_sign, {(RW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_exp        <= '0;
      s1_frac       <= '0;
      s1_guard      <= 1'b0;
      s1_sticky     <= 1'b0;
      s1_dec        <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_decrement <= 1'b0;
      out_of        <= 1'b0;
      out_uf        <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign   <= in_sign;
          s1_exp    <= e1_c;
          s1_frac   <= frac_c;
          s1_guard  <= guard_c;
          s1_sticky <= sticky_c;
          s1_dec    <= dec_c;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result    <= result_c;
          out_decrement <= s1_dec;
          out_of        <= of_c;
          out_uf        <= uf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_div_normalize.sv
// Self-checking bench for fp_div_normalize: directed spec vectors, backpressure,
// streaming, randomized traffic against a value-level rounding model, and reset.
module tb_fp_div_normalize;
  import fp_div_normalize_pkg::*;

  localparam int unsigned EW = FP_EXP_W + 2;
  localparam int unsigned QW = FP_FRAC_W + 3;
  localparam int unsigned RW = 1 + FP_EXP_W + FP_FRAC_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [EW-1:0] in_exp = '0;
  logic [QW-1:0] in_q = '0;
  logic          in_rem_nz = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_result;
  logic          out_decrement;
  logic          out_of;
  logic          out_uf;

  always #5 clk = ~clk;

  fp_div_normalize dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_q          (in_q),
    .in_rem_nz     (in_rem_nz),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_decrement (out_decrement),
    .out_of        (out_of),
    .out_uf        (out_uf)
  );

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [QW-1:0] q;
    logic          rnz;
  } item_t;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          dec;
    logic          of;
    logic          uf;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  in_fire, out_fire, o_valid, i_ready;
  exp_t  obs;
  item_t idle_it;

  always @(posedge clk)
    if (!reset && in_valid)
      assert (in_q[QW-1:QW-2] != 2'b00) else $error("illegal in_q below 0.5 driven");

  // Value-level model: keep 24 significant bits, round the dropped tail to nearest even.
  function automatic exp_t model(input item_t it);
    exp_t   m;
    fp_t    f;
    int     e, drop;
    longint kept, rem, half;
    logic   up;
    e    = int'($signed(it.exp));
    drop = it.q[QW-1] ? 2 : 1;
    if (!it.q[QW-1]) e = e - 1;
    kept = longint'(it.q) >> drop;
    rem  = longint'(it.q) - (kept << drop);
    half = longint'(1) << (drop - 1);
    up   = (rem > half) || ((rem == half) && (it.rnz || (kept % 2 == 1)));
    if (up) kept = kept + 1;
    if (kept == (longint'(1) << (FP_FRAC_W + 1))) begin
      kept = kept / 2;
      e    = e + 1;
    end
    m.of = 1'b0;
    m.uf = 1'b0;
    f.sign = it.sign;
    if (e >= int'(FP_EXP_ONES)) begin
      f.exp = '1; f.frac = '0; m.of = 1'b1;
    end else if (e <= 0) begin
      f.exp = '0; f.frac = '0; m.uf = 1'b1;
    end else begin
      f.exp  = FP_EXP_W'(e);
      f.frac = FP_FRAC_W'(kept);
    end
    m.res = f;
    m.dec = !it.q[QW-1];
    return m;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    int    e;
    it.sign = 1'($urandom);
    it.rnz  = 1'($urandom);
    it.q    = QW'($urandom);
    if (it.q[QW-1:QW-2] == 2'b00) it.q[QW-2] = 1'b1;
    case ($urandom_range(0, 9))
      0:       e = int'($urandom_range(248, 258));
      1:       e = int'($urandom_range(0, 6)) - 3;
      default: e = int'($urandom_range(1, 254));
    endcase
    it.exp = EW'(e);
    return it;
  endfunction

  // One clock: drive at negedge, sample just after, queue expected result on input transfer.
  task automatic cycle(input logic iv, input item_t it, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_sign   = it.sign;
    in_exp    = it.exp;
    in_q      = it.q;
    in_rem_nz = it.rnz;
    out_ready = ordy;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    o_valid  = out_valid;
    i_ready  = in_ready;
    obs      = {out_result, out_decrement, out_of, out_uf};
    if (in_fire) exp_q.push_back(model(it));
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_result, out_decrement, out_of, out_uf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h dec=%b of=%b uf=%b want all 0",
               out_valid, out_result, out_decrement, out_of, out_uf);
    end
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, idle_it, 1'b1);
    checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", i_ready, o_valid);
    end
  endtask

  task automatic test_directed();
    item_t v[5];
    exp_t  want[5];
    int    lat;
    v[0] = '{sign:1'b0, exp:EW'(128), q:QW'(26'h3000000), rnz:1'b0};
    want[0] = '{res:32'h40400000, dec:1'b0, of:1'b0, uf:1'b0};
    v[1] = '{sign:1'b0, exp:EW'(126), q:QW'(26'h1555555), rnz:1'b1};
    want[1] = '{res:32'h3EAAAAAB, dec:1'b1, of:1'b0, uf:1'b0};
    v[2] = '{sign:1'b0, exp:EW'(127), q:QW'(26'h3FFFFFF), rnz:1'b0};
    want[2] = '{res:32'h40000000, dec:1'b0, of:1'b0, uf:1'b0};
    v[3] = '{sign:1'b0, exp:EW'(255), q:QW'(26'h2000000), rnz:1'b0};
    want[3] = '{res:32'h7F800000, dec:1'b0, of:1'b1, uf:1'b0};
    v[4] = '{sign:1'b1, exp:EW'(1), q:QW'(26'h1000000), rnz:1'b0};
    want[4] = '{res:32'h80000000, dec:1'b1, of:1'b0, uf:1'b1};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, v[i], 1'b1);
      lat = 0;
      while (lat < 6) begin
        cycle(1'b0, idle_it, 1'b1);
        lat++;
        if (out_fire) break;
      end
      checks++;
      if (!out_fire || lat != 2) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got fired=%b after %0d cycles want 2", i, out_fire, lat);
      end
      checks++;
      if (obs !== want[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got res=%h dec=%b of=%b uf=%b want res=%h dec=%b of=%b uf=%b",
                 i, obs.res, obs.dec, obs.of, obs.uf, want[i].res, want[i].dec, want[i].of, want[i].uf);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    item_t items[4];
    exp_t  held, e;
    int    idx = 0;
    int    cyc = 0;
    for (int i = 0; i < 4; i++) items[i] = rand_item();
    while ((idx < 4 || exp_q.size() != 0) && cyc < 40) begin
      cycle(idx < 4, items[idx < 4 ? idx : 0], cyc >= 3);
      if (cyc == 2) begin
        held = obs;
        checks++;
        if (i_ready !== 1'b0 || idx != 2 || o_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_stall: got in_ready=%b accepted=%0d out_valid=%b want 0 2 1", i_ready, idx, o_valid);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (obs !== held) begin
          errors++;
          $display("FAIL bp_hold: got %h want %h", obs, held);
        end
      end
      if (in_fire) idx++;
      if (out_fire) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL bp_result: got %h want %h", obs, e);
        end
      end
      cyc++;
    end
    checks++;
    if (idx != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: got sent=%0d pending=%0d want 4 0", idx, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int   n = 32, sent = 0, outs = 0, first = -1, last = -1, stalls = 0, cyc = 0;
    logic iv;
    exp_t e;
    while ((sent < n || exp_q.size() != 0) && cyc < 200) begin
      iv = (sent < n);
      cycle(iv, rand_item(), 1'b1);
      if (iv && !in_fire) stalls++;
      if (in_fire) sent++;
      if (out_fire) begin
        outs++;
        if (first < 0) first = cyc;
        last = cyc;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL b2b_result: got %h want %h", obs, e);
        end
      end
      cyc++;
    end
    checks++;
    if (stalls != 0 || outs != n || first != 2 || (last - first + 1) != n) begin
      errors++;
      $display("FAIL b2b_throughput: got stalls=%0d outs=%0d first=%0d span=%0d want 0 %0d 2 %0d",
               stalls, outs, first, last - first + 1, n, n);
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    int   n = 300, sent = 0, cyc = 0;
    logic iv, prev_hold = 1'b0;
    exp_t prev, e;
    while ((sent < n || exp_q.size() != 0) && cyc < 3000) begin
      iv = (sent < n) && ($urandom_range(0, 9) < 8);
      cycle(iv, rand_item(), $urandom_range(0, 9) < 7);
      if (prev_hold) begin
        checks++;
        if (o_valid !== 1'b1 || obs !== prev) begin
          errors++;
          $display("FAIL rand_hold: got valid=%b %h want 1 %h", o_valid, obs, prev);
        end
      end
      prev_hold = o_valid && !out_fire;
      prev = obs;
      if (in_fire) sent++;
      if (out_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got unexpected %h want nothing", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL rand_result: got %h want %h", obs, e);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (sent != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout: got sent=%0d pending=%0d want %0d 0", sent, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_inflight();
    int acc = 0;
    cycle(1'b1, rand_item(), 1'b0);
    if (in_fire) acc++;
    cycle(1'b1, rand_item(), 1'b0);
    if (in_fire) acc++;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (acc != 2 || out_valid !== 1'b0 || out_result !== '0) begin
      errors++;
      $display("FAIL rst_async: got accepted=%0d out_valid=%b res=%h want 2 0 0", acc, out_valid, out_result);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, idle_it, 1'b1);
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_stale[%0d]: got out_valid=%b in_ready=%b want 0 1", i, o_valid, i_ready);
      end
    end
  endtask

  initial begin
    idle_it = '0;
    idle_it.q[QW-1] = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_normalize.md
Name: fp_div_normalize

Overview:
- Back end of the divide datapath. Consumes the unnormalized quotient mantissa, sign and pre-decrement biased exponent produced by the exponent/mantissa front end.
- Detects whether the quotient needs a 1-bit left normalization shift; that is the decrement the exponent path needs.
- Applies the shift, rounds to nearest-even, checks exponent range and packs an IEEE-754 result.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, stored fraction width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  upstream result available
- in_ready  output  1  block can accept this cycle
- in_sign  input  1  result sign
- in_exp  input  EXP_W+2  signed biased exponent (e1-e2+bias), not yet decremented, no wrap
- in_q  input  FRAC_W+3  quotient, 1 integer bit + FRAC_W+2 fraction bits, value in [0.5,2)
- in_rem_nz  input  1  remainder nonzero (sticky)
- out_valid  output  1  packed result valid
- out_ready  input  1  downstream accepts
- out_result  output  1+EXP_W+FRAC_W  {sign, exp, frac}
- out_decrement  output  1  normalization shift applied to this result
- out_of  output  1  overflow flag
- out_uf  output  1  underflow flag

Behaviour:
- Reset: all stage valids 0; out_valid, out_result, out_decrement, out_of, out_uf = 0; in_ready = 1 the cycle after reset deasserts. Reset mid-operation discards all in-flight results without emitting them.
- Handshake: a transfer occurs when valid & ready are both high on a clk edge.
  - in_ready = !s1_valid | s2_free.
  - s2_free = !out_valid | out_ready.
  - in_ready must not depend combinationally on in_valid.
  - out_* hold stable while out_valid & !out_ready.
- Latency: 2 cycles from input transfer to out_valid. Throughput 1 result/cycle with out_ready held high. Ordering is preserved.
- Stage 1 (normalize), dec = ~in_q[FRAC_W+2]:
  - dec=0: frac = q[FRAC_W+1:2], guard = q[1], sticky = q[0] | rem_nz.
  - dec=1: frac = q[FRAC_W:1], guard = q[0], sticky = rem_nz.
  - e1 = in_exp - dec, signed EXP_W+2 arithmetic.
  - Register sign, e1, frac, guard, sticky, dec.
- Stage 2 (round/pack):
  - inc = guard & (sticky | frac[0]). frac_r = frac + inc, FRAC_W+1 bits.
  - If frac_r carries out: frac = 0, e2 = e1 + 1. Otherwise e2 = e1.
  - e2 >= 2^EXP_W-1: result = {sign, all ones, 0} (infinity), of = 1.
  - e2 <= 0: result = {sign, 0, 0} (flush to signed zero, no subnormals), uf = 1.
  - Otherwise: normal pack, of = uf = 0.
  - out_decrement = the stage-1 dec for this result.
- Only the normal/overflow/underflow cases above are handled: NaN, infinity and zero operands are resolved upstream and never enter this block.
- in_q with integer bit 0 and the MSB fraction bit 0 (value < 0.5) is illegal. The bench flags it as an assertion violation; the block's response to it is undefined.

Decomposition:
- Shared fp package holds:
  - bias constant 2**(EXP_W-1)-1
  - exponent-all-ones constant
  - packed-float struct typedef {sign, exp, frac}
  - rounding-mode enum, RNE only for now, reserved for later modes
- One natural sub-module: fp_round_rne, combinational. It takes frac, guard, sticky and returns the rounded frac plus a carry. It is reused by the multiply path later.
- Pipeline registers and handshake logic stay in fp_div_normalize.

Test Plan:
- 6.0/2.0: in_exp=128, in_q=0x3000000, rem_nz=0 -> out_result=0x40400000, decrement=0, of=uf=0, out_valid 2 cycles after accept.
- 1.0/3.0: in_exp=126, in_q=0x1555555, rem_nz=1 -> dec=1, round up, out_result=0x3EAAAAAB, decrement=1.
- Rounding carry: in_exp=127, in_q=0x3FFFFFF, rem_nz=0 -> out_result=0x40000000 (exponent bumped, frac 0).
- Range:
  - in_exp=255, in_q=0x2000000 -> 0x7F800000, of=1.
  - sign=1, in_exp=1, in_q=0x1000000 -> 0x80000000, uf=1.
- Backpressure:
  - Stream 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, the held output stays stable, all 4 emerge in order once out_ready=1.
  - With out_ready held 1: one result per cycle, no bubbles.
- Reset asserted with 2 results in flight -> out_valid=0 immediately (async), no stale output after release, in_ready=1.
